// File: rtl/four_bit_sync_updown_counter.sv
// Up/down binary counter with parallel load, combinational terminal count and registered wrap pulse.
// Latency: count and wrap update one clk edge after up_down/load are sampled; tc is same-cycle combinational.
// Backpressure: none; counts every edge unless loading. Build macro UPDOWN_SATURATE_EN selects saturating mode.
module four_bit_sync_updown_counter #(
   parameter int unsigned         WIDTH     = 4,
   parameter logic [WIDTH-1:0]    RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             up_down,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] ALL_ONES = '1;
   localparam logic [WIDTH-1:0] ZERO     = '0;
   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic             wrap_q;
   logic             wrap_d;
   logic             at_max;
   logic             at_min;

   // Boundary detection shared by next-state logic and the terminal-count flag.
   always_comb begin
      at_max = (count_q == ALL_ONES);
      at_min = (count_q == ZERO);
   end

   // Next count: load overrides counting; wrap flags the edge that crosses the boundary.
   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      if (load) begin
         count_d = load_val;
      end else if (up_down) begin
`ifdef UPDOWN_SATURATE_EN
         if (!at_max) begin
            count_d = count_q + ONE;
         end
`else
         count_d = count_q + ONE;
         wrap_d  = at_max;
`endif
      end else begin
`ifdef UPDOWN_SATURATE_EN
         if (!at_min) begin
            count_d = count_q - ONE;
         end
`else
         count_d = count_q - ONE;
         wrap_d  = at_min;
`endif
      end
   end

   // State registers; reset acts immediately and holds while rst is low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= RESET_VAL;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
      end
   end

   // Terminal count looks at the direction currently requested, not the last one used.
   always_comb begin
      tc = up_down ? at_max : at_min;
   end

   assign count = count_q;
   assign wrap  = wrap_q;

endmodule

// File: tb/tb_four_bit_sync_updown_counter.sv
// Directed bench for four_bit_sync_updown_counter with hand-computed expectations.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Expectations switch on UPDOWN_SATURATE_EN so the bench covers both builds.
module tb_four_bit_sync_updown_counter;

`ifdef UPDOWN_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic       up_down;
   logic       load;
   logic [3:0] load_val;
   logic [3:0] count;
   logic       tc;
   logic       wrap;

   int tests_run;
   int tests_failed;

   four_bit_sync_updown_counter #(
      .WIDTH    (4),
      .RESET_VAL(4'b0000)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .up_down (up_down),
      .load    (load),
      .load_val(load_val),
      .count   (count),
      .tc      (tc),
      .wrap    (wrap)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_cnt(input string tag, input logic [3:0] exp);
      tests_run++;
      assert (count === exp) else begin
         tests_failed++;
         $error("FAIL %s count: observed %b expected %b", tag, count, exp);
      end
   endtask

   task automatic chk_wrap(input string tag, input logic exp);
      tests_run++;
      assert (wrap === exp) else begin
         tests_failed++;
         $error("FAIL %s wrap: observed %b expected %b", tag, wrap, exp);
      end
   endtask

   task automatic chk_tc(input string tag, input logic exp);
      tests_run++;
      assert (tc === exp) else begin
         tests_failed++;
         $error("FAIL %s tc: observed %b expected %b", tag, tc, exp);
      end
   endtask

   // One clock edge followed by checks of count and wrap.
   task automatic step(input string tag, input logic [3:0] exp_cnt, input logic exp_wrap);
      tick();
      chk_cnt(tag, exp_cnt);
      chk_wrap(tag, exp_wrap);
   endtask

   // Synchronous load of a starting value.
   task automatic do_load(input logic [3:0] v);
      load     = 1'b1;
      load_val = v;
      step("load", v, 1'b0);
      load     = 1'b0;
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst      = 1'b0;
      up_down  = 1'b1;
      load     = 1'b0;
      load_val = 4'b0000;

      // Reset state before any edge, then held across edges.
      #2;
      chk_cnt("rst_pre_edge", 4'b0000);
      chk_wrap("rst_pre_edge", 1'b0);
      chk_tc("rst_pre_edge", 1'b0);
      up_down = 1'bx;
      step("rst_hold_x", 4'b0000, 1'b0);
      up_down = 1'b1;
      step("rst_hold_1", 4'b0000, 1'b0);

      // Release reset mid-cycle; count up through the full range.
      rst = 1'b1;
      for (int i = 1; i <= 15; i++) begin
         step($sformatf("up_%0d", i), 4'(i), 1'b0);
      end
      chk_tc("tc_at_1111_up", 1'b1);
      step("up_wrap", SAT ? 4'b1111 : 4'b0000, SAT ? 1'b0 : 1'b1);
      chk_tc("tc_after_up_wrap", SAT ? 1'b1 : 1'b0);
      step("up_after_wrap", SAT ? 4'b1111 : 4'b0001, 1'b0);

      // Count down across zero.
      do_load(4'b0010);
      up_down = 1'b0;
      chk_tc("tc_0010_down", 1'b0);
      step("down_1", 4'b0001, 1'b0);
      step("down_0", 4'b0000, 1'b0);
      chk_tc("tc_at_0000_down", 1'b1);
      step("down_wrap", SAT ? 4'b0000 : 4'b1111, SAT ? 1'b0 : 1'b1);
      chk_tc("tc_after_down_wrap", SAT ? 1'b1 : 1'b0);
      step("down_after_wrap", SAT ? 4'b0000 : 4'b1110, 1'b0);

      // Direction toggling: no skipped or repeated values.
      do_load(4'b0000);
      up_down = 1'b1;
      step("dir_up_1", 4'b0001, 1'b0);
      step("dir_up_2", 4'b0010, 1'b0);
      step("dir_up_3", 4'b0011, 1'b0);
      up_down = 1'b0;
      step("dir_dn_1", 4'b0010, 1'b0);
      step("dir_dn_2", 4'b0001, 1'b0);
      up_down = 1'b1;
      step("dir_up_4", 4'b0010, 1'b0);

      // Load has priority over counting; load_val ignored when load=0.
      do_load(4'b0101);
      load     = 1'b1;
      load_val = 4'b1100;
      up_down  = 1'b1;
      step("load_prio", 4'b1100, 1'b0);
      load     = 1'b0;
      step("after_load", 4'b1101, 1'b0);
      load_val = 4'b0011;
      step("load_val_ignored", 4'b1110, 1'b0);

      // Load at all-ones while counting up: no wrap pulse.
      do_load(4'b1111);
      load     = 1'b1;
      load_val = 4'b0111;
      step("load_at_max", 4'b0111, 1'b0);
      load     = 1'b0;

      // Async reset between edges.
      do_load(4'b1010);
      #3;
      rst = 1'b0;
      #1;
      chk_cnt("async_rst_mid", 4'b0000);
      chk_wrap("async_rst_mid", 1'b0);
      tick();
      rst = 1'b1;
      step("resume_after_rst", 4'b0001, 1'b0);

      // Async reset clears a pending wrap pulse.
      do_load(4'b1111);
      step("wrap_before_rst", SAT ? 4'b1111 : 4'b0000, SAT ? 1'b0 : 1'b1);
      #3;
      rst = 1'b0;
      #1;
      chk_cnt("rst_clears_wrap", 4'b0000);
      chk_wrap("rst_clears_wrap", 1'b0);
      tick();
      rst = 1'b1;
      tick();

      // Saturation boundaries (modulo in the default build).
      do_load(4'b1110);
      up_down = 1'b1;
      step("sat_up_1", 4'b1111, 1'b0);
      step("sat_up_2", SAT ? 4'b1111 : 4'b0000, SAT ? 1'b0 : 1'b1);
      do_load(4'b0001);
      up_down = 1'b0;
      step("sat_dn_1", 4'b0000, 1'b0);
      step("sat_dn_2", SAT ? 4'b0000 : 4'b1111, SAT ? 1'b0 : 1'b1);
      chk_tc("tc_sat_dn", SAT ? 1'b1 : 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
